// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared state encoding and default sizing for the generation scheduler
package gol_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 25000000;
  localparam int unsigned GEN_W_DEFAULT    = 32;

  typedef enum logic [4:0] {
    ST_PAUSE     = 5'b00001,
    ST_EDIT      = 5'b00010,
    ST_WAIT_TICK = 5'b00100,
    ST_COMPUTE   = 5'b01000,
    ST_COMMIT    = 5'b10000
  } state_e;

endpackage

// File: rtl/gol_tick_divider.sv
// rtl/gol_tick_divider.sv - generation-rate counter; tc_o marks the last of TICK_DIV waiting cycles
module gol_tick_divider
  import gol_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Held at zero while reload is high, so the first counting cycle always reads 0.
  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = !reload_i && (cnt_q == LAST);

endmodule

// File: rtl/gol_gen_scheduler.sv
// rtl/gol_gen_scheduler.sv - run/pause/step/edit sequencing of Game-of-Life generations
// Optional GOL_STABLE_HALT_EN: a commit of an unchanged board stops run mode without counting.
module gol_gen_scheduler
  import gol_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned GEN_W    = GEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_toggle,
  input  logic             step,
  input  logic             edit_req,
  input  logic             alg_done,
  input  logic             board_changed,
  output logic             edit_grant,
  output logic             alg_start,
  output logic             commit,
  output logic             running,
  output logic             busy,
  output logic [GEN_W-1:0] generation_cnt
);

  state_e           state_q, state_d;
  logic             running_q, running_d;
  logic             busy_q, busy_d;
  logic             alg_start_q, alg_start_d;
  logic             commit_q, commit_d;
  logic             edit_grant_q, edit_grant_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             pend_edit_q, pend_edit_d;
  logic             pend_tog_q, pend_tog_d;
  logic             halt;
  logic             tick_tc;

`ifdef GOL_STABLE_HALT_EN
  logic changed_q, changed_d;
`else
  logic unused_board_changed;
  assign unused_board_changed = board_changed;
`endif

  gol_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .reload_i (state_q != ST_WAIT_TICK),
    .tc_o     (tick_tc)
  );

  always_comb begin
    state_d      = state_q;
    running_d    = running_q;
    busy_d       = 1'b0;
    alg_start_d  = 1'b0;
    commit_d     = 1'b0;
    edit_grant_d = 1'b0;
    gen_d        = gen_q;
    pend_edit_d  = pend_edit_q;
    pend_tog_d   = pend_tog_q;
    halt         = 1'b0;
`ifdef GOL_STABLE_HALT_EN
    changed_d    = changed_q;
    halt         = !changed_q;
`endif

    case (state_q)
      ST_PAUSE: begin
        if (edit_req) begin
          state_d      = ST_EDIT;
          edit_grant_d = 1'b1;
          gen_d        = '0;
        end else if (run_toggle) begin
          state_d   = ST_WAIT_TICK;
          running_d = 1'b1;
        end else if (step) begin
          state_d     = ST_COMPUTE;
          alg_start_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_EDIT: begin
        if (!edit_req) begin
          state_d = ST_PAUSE;
        end else begin
          edit_grant_d = 1'b1;
        end
      end

      ST_WAIT_TICK: begin
        if (edit_req) begin
          state_d      = ST_EDIT;
          edit_grant_d = 1'b1;
          gen_d        = '0;
          running_d    = 1'b0;
        end else if (run_toggle) begin
          state_d   = ST_PAUSE;
          running_d = 1'b0;
        end else if (tick_tc) begin
          state_d     = ST_COMPUTE;
          alg_start_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_COMPUTE: begin
        busy_d      = 1'b1;
        pend_edit_d = pend_edit_q | edit_req;
        pend_tog_d  = pend_tog_q | run_toggle;
        if (alg_done) begin
          state_d  = ST_COMMIT;
          commit_d = 1'b1;
`ifdef GOL_STABLE_HALT_EN
          changed_d = board_changed;
`endif
        end
      end

      ST_COMMIT: begin
        // Requests collected during the evaluation override the normal successor.
        pend_edit_d = 1'b0;
        pend_tog_d  = 1'b0;
        if (pend_edit_q || edit_req) begin
          state_d      = ST_EDIT;
          edit_grant_d = 1'b1;
          gen_d        = '0;
          running_d    = 1'b0;
        end else if (halt) begin
          state_d   = ST_PAUSE;
          running_d = 1'b0;
        end else begin
          gen_d = gen_q + 1'b1;
          if (pend_tog_q || run_toggle) begin
            running_d = !running_q;
            state_d   = running_q ? ST_PAUSE : ST_WAIT_TICK;
          end else begin
            state_d = running_q ? ST_WAIT_TICK : ST_PAUSE;
          end
        end
      end

      default: begin
        state_d   = ST_PAUSE;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_PAUSE;
      running_q    <= 1'b0;
      busy_q       <= 1'b0;
      alg_start_q  <= 1'b0;
      commit_q     <= 1'b0;
      edit_grant_q <= 1'b0;
      gen_q        <= '0;
      pend_edit_q  <= 1'b0;
      pend_tog_q   <= 1'b0;
`ifdef GOL_STABLE_HALT_EN
      changed_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      busy_q       <= busy_d;
      alg_start_q  <= alg_start_d;
      commit_q     <= commit_d;
      edit_grant_q <= edit_grant_d;
      gen_q        <= gen_d;
      pend_edit_q  <= pend_edit_d;
      pend_tog_q   <= pend_tog_d;
`ifdef GOL_STABLE_HALT_EN
      changed_q    <= changed_d;
`endif
    end
  end

  assign edit_grant     = edit_grant_q;
  assign alg_start      = alg_start_q;
  assign commit         = commit_q;
  assign running        = running_q;
  assign busy           = busy_q;
  assign generation_cnt = gen_q;

endmodule

// File: doc/gol_gen_scheduler.md
GOL_GEN_SCHEDULER -- requirements
Module: gol_gen_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25000000: clk cycles spent in WAIT_TICK per generation in run mode; legal range >= 2.
REQ-002 Parameter GEN_W, default 32: width of generation_cnt.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 run_toggle  input  1  single-cycle pulse; toggles between run and pause.
REQ-006 step  input  1  single-cycle pulse; advances one generation while paused.
REQ-007 edit_req  input  1  level; set-up writer requests board ownership.
REQ-008 alg_done  input  1  single-cycle pulse from the algorithm engine; next board ready.
REQ-009 board_changed  input  1  valid only in the alg_done cycle; next board differs from current board.
REQ-010 edit_grant  output  1  high only in EDIT.
REQ-011 alg_start  output  1  single-cycle pulse launching one engine evaluation.
REQ-012 commit  output  1  single-cycle pulse; copy the engine's next board into the current board.
REQ-013 running  output  1  run mode active.
REQ-014 busy  output  1  high in COMPUTE and COMMIT.
REQ-015 generation_cnt  output  GEN_W  committed generations since the last edit.

Function
REQ-016 States: PAUSE, EDIT, WAIT_TICK, COMPUTE, COMMIT; all outputs are registered.
REQ-017 PAUSE: edit_req -> EDIT; run_toggle -> WAIT_TICK with running=1; step -> COMPUTE; priority edit_req > run_toggle > step; lower-priority pulses are dropped.
REQ-018 EDIT: on entry, generation_cnt is cleared to 0 and step and run_toggle are ignored; when edit_req falls, go to PAUSE.
REQ-019 WAIT_TICK: the tick counter reloads on entry and reaches terminal count after exactly TICK_DIV cycles, then goes to COMPUTE; run_toggle -> PAUSE with running=0; edit_req -> EDIT with running=0.
REQ-020 COMPUTE: alg_start is high only in the first COMPUTE cycle; stay until alg_done, then go to COMMIT; no timeout.
REQ-021 COMMIT lasts exactly one cycle, with commit=1; on exit, generation_cnt increments and the state goes to WAIT_TICK if running, else PAUSE.
REQ-022 A run_toggle or edit_req arriving in COMPUTE or COMMIT is held pending and applied on COMMIT exit, instead of the normal successor state.
REQ-023 edit_grant is never asserted while busy=1, so board ownership never overlaps an evaluation.
REQ-024 alg_done outside COMPUTE is ignored; step while running=1 is ignored.
REQ-025 generation_cnt wraps modulo 2^GEN_W without a flag.
REQ-026 Step latency: a step pulse sampled in PAUSE at edge N gives alg_start high in cycle N+1; commit is high in the cycle after alg_done is sampled.

Reset
REQ-027 reset_n low forces, asynchronously: state PAUSE; running, busy, alg_start, commit and edit_grant all 0; generation_cnt 0; tick counter 0; pending flags cleared.
REQ-028 A reset during COMPUTE discards the evaluation; no commit is issued and any later alg_done is ignored.

Configuration
REQ-029 Macro GOL_STABLE_HALT_EN defined: in COMMIT, if board_changed was 0 at alg_done, commit still pulses, generation_cnt does not increment, running clears and the next state is PAUSE.
REQ-030 Macro GOL_STABLE_HALT_EN undefined: board_changed is ignored and behaviour follows REQ-021.

Structure
REQ-031 Package gol_pkg holds the state encoding (one-hot, 5 bits) and the default TICK_DIV and GEN_W constants.
REQ-032 Sub-module gol_tick_divider (reload input, terminal-count output, TICK_DIV parameter) implements the WAIT_TICK counter.

Verification
REQ-033 TICK_DIV=4, reset released, run_toggle pulse -> running=1, alg_start every 4+L+2 cycles (L = engine latency), generation_cnt 1, 2, 3.
REQ-034 Paused, step pulse, engine alg_done after 3 cycles -> exactly one alg_start and one commit, generation_cnt 0->1, state back to PAUSE.
REQ-035 edit_req raised during COMPUTE -> edit_grant stays 0 until after commit, then 1; generation_cnt reads 0 in EDIT.
REQ-036 reset_n pulled low mid-COMPUTE, then alg_done pulsed -> no commit, all outputs at reset values, state PAUSE.
REQ-037 GOL_STABLE_HALT_EN defined, running, alg_done with board_changed=0 -> commit pulses, generation_cnt unchanged, running=0.
REQ-038 run_toggle and step in the same cycle while in PAUSE -> WAIT_TICK entered and no immediate alg_start.
